// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and index helpers for the systolic feeder
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    // Bit offset of element [row][col] in a row-major packed matrix.
    function automatic int elem_index(input int row, input int col,
                                      input int max_dim, input int data_width);
        return (row * max_dim + col) * data_width;
    endfunction

    // Zero vectors after the last feed so the final products reach the far corner PE.
    function automatic int drain_cycles(input int n);
        return n;
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// rtl/skew_lane_mux.sv - picks element [LANE][t-LANE] of a latched matrix, zero when out of range
module skew_lane_mux
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 2,
    parameter int LANE       = 0,
    parameter int CW         = 2,
    parameter int DW         = 2
) (
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] mat,
    input  logic [CW-1:0]                         t,
    input  logic [DW-1:0]                         n,
    output logic [DATA_WIDTH-1:0]                 elem
);

    int k;

    always_comb begin
        k    = int'(t) - LANE;
        elem = '0;
        if ((LANE < int'(n)) && (k >= 0) && (k < int'(n))) begin
            elem = mat[elem_index(LANE, k, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - latches A/B and streams them skewed into systolic_array (optional FEEDER_B_TRANSPOSE_EN)
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [$clog2(MAX_DIM+1)-1:0]          dim,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] mat_a,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] mat_b,
`ifdef FEEDER_B_TRANSPOSE_EN
    input  logic                                  b_transposed,
`endif
    output logic [MAX_DIM*DATA_WIDTH-1:0]         a_vec,
    output logic [MAX_DIM*DATA_WIDTH-1:0]         b_vec,
    output logic                                  array_clr,
    output logic                                  busy,
    output logic                                  done
);

    localparam int DW = $clog2(MAX_DIM + 1);
    localparam int CW = $clog2(2 * MAX_DIM);
    localparam int MW = MAX_DIM * MAX_DIM * DATA_WIDTH;
    localparam int VW = MAX_DIM * DATA_WIDTH;
    localparam logic [DW-1:0] MAX_N = DW'(MAX_DIM);

    feeder_state_t state;
    feeder_state_t state_next;

    logic [CW-1:0] cnt;
    logic [DW-1:0] n_lat;
    logic [DW-1:0] n_clamped;
    logic [MW-1:0] a_lat;
    logic [MW-1:0] b_lat;
    logic [CW-1:0] feed_last;
    logic [CW-1:0] drain_last;
    logic [VW-1:0] a_lanes;
    logic [VW-1:0] b_lanes;

    function automatic logic [MW-1:0] transpose(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
                r[elem_index(i, j, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH] =
                    m[elem_index(j, i, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    always_comb begin
        n_clamped  = ((dim == '0) || (dim > MAX_N)) ? MAX_N : dim;
        feed_last  = (CW'(n_lat) << 1) - CW'(2);
        drain_last = CW'(drain_cycles(int'(n_lat)) - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_FEED;
            ST_FEED:  if (cnt == feed_last) state_next = ST_DRAIN;
            ST_DRAIN: if (cnt == drain_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // B is stored transposed so both operands use the same [lane][t-lane] selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            n_lat <= '0;
            a_lat <= '0;
            b_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        n_lat <= n_clamped;
                        a_lat <= mat_a;
`ifdef FEEDER_B_TRANSPOSE_EN
                        b_lat <= b_transposed ? mat_b : transpose(mat_b);
`else
                        b_lat <= transpose(mat_b);
`endif
                    end
                end
                ST_FEED:  cnt <= (cnt == feed_last) ? '0 : cnt + CW'(1);
                ST_DRAIN: cnt <= (cnt == drain_last) ? '0 : cnt + CW'(1);
                default:  cnt <= '0;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
        skew_lane_mux #(
            .DATA_WIDTH(DATA_WIDTH),
            .MAX_DIM   (MAX_DIM),
            .LANE      (g),
            .CW        (CW),
            .DW        (DW)
        ) u_a_mux (
            .mat (a_lat),
            .t   (cnt),
            .n   (n_lat),
            .elem(a_lanes[g*DATA_WIDTH +: DATA_WIDTH])
        );

        skew_lane_mux #(
            .DATA_WIDTH(DATA_WIDTH),
            .MAX_DIM   (MAX_DIM),
            .LANE      (g),
            .CW        (CW),
            .DW        (DW)
        ) u_b_mux (
            .mat (b_lat),
            .t   (cnt),
            .n   (n_lat),
            .elem(b_lanes[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vec     <= '0;
            b_vec     <= '0;
            array_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            a_vec     <= (state == ST_FEED) ? a_lanes : '0;
            b_vec     <= (state == ST_FEED) ? b_lanes : '0;
            array_clr <= (state == ST_CLEAR);
            busy      <= (state == ST_CLEAR) || (state == ST_FEED) || (state == ST_DRAIN);
            done      <= (state == ST_DONE);
        end
    end

endmodule
